// File: rtl/clk_div_multi.sv
// clk_div_multi
// Multi-channel programmable clock divider and tick generator.
// A free-running cycle counter `div` is kept for existing consumers. Each
// channel has its own divisor D, giving a one-cycle `tick` every D+1 enabled
// cycles and a 50%-duty square wave `sq` that toggles on every tick.
// A divisor written while a channel runs is held in a shadow register and
// applied only at the next period boundary, so the running period is never
// shortened or stretched.

module clk_div_multi #(
   parameter int          CHANNELS  = 4,
   parameter int          WIDTH     = 32,
   parameter int          CNT_WIDTH = 32,
   parameter int unsigned RESET_DIV = 0,
   parameter int          CH_BITS   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [CHANNELS-1:0]  en,
   input  logic                 wr_en,
   input  logic [CH_BITS-1:0]   wr_ch,
   input  logic [WIDTH-1:0]     wr_data,
   output logic [CNT_WIDTH-1:0] div,
   output logic [CHANNELS-1:0]  tick,
   output logic [CHANNELS-1:0]  sq,
   output logic [CHANNELS-1:0]  pending
);

   localparam logic [WIDTH-1:0] RST_D = WIDTH'(RESET_DIV);

   logic [WIDTH-1:0]    cnt    [CHANNELS];
   logic [WIDTH-1:0]    act    [CHANNELS];
   logic [WIDTH-1:0]    shadow [CHANNELS];
   logic [CHANNELS-1:0] wr_hit;

   // Decode the write strobe into a per-channel hit; indices beyond the
   // channel count never match, so such writes are silently dropped.
   always_comb begin
      wr_hit = '0;
      for (int i = 0; i < CHANNELS; i++) begin
         wr_hit[i] = wr_en && (wr_ch == CH_BITS'(i));
      end
   end

   // Free-running cycle counter, independent of enables and writes.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         div <= '0;
      end else begin
         div <= div + CNT_WIDTH'(1);
      end
   end

   // Per-channel counter, divisor hand-over and tick/square-wave generation.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tick    <= '0;
         sq      <= '0;
         pending <= '0;
         for (int i = 0; i < CHANNELS; i++) begin
            cnt[i]    <= '0;
            act[i]    <= RST_D;
            shadow[i] <= RST_D;
         end
      end else begin
         for (int i = 0; i < CHANNELS; i++) begin
            if (!en[i]) begin
               tick[i] <= 1'b0;
               if (wr_hit[i]) begin
                  act[i]     <= wr_data;
                  shadow[i]  <= wr_data;
                  cnt[i]     <= '0;
                  pending[i] <= 1'b0;
               end
            end else if (cnt[i] == act[i]) begin
               cnt[i]     <= '0;
               tick[i]    <= 1'b1;
               sq[i]      <= ~sq[i];
               pending[i] <= 1'b0;
               if (wr_hit[i]) begin
                  act[i] <= wr_data;
               end else if (pending[i]) begin
                  act[i] <= shadow[i];
               end
            end else begin
               cnt[i]  <= cnt[i] + WIDTH'(1);
               tick[i] <= 1'b0;
               if (wr_hit[i]) begin
                  shadow[i]  <= wr_data;
                  pending[i] <= 1'b1;
               end
            end
         end
      end
   end

endmodule
